// File: rtl/uart_main_top.sv
// Full-duplex 8N1 UART endpoint: sends a W_OUT-bit word as NUM_WORDS frames (LSB byte first)
// and reassembles NUM_WORDS received frames into one word with a single-cycle m_valid strobe.
module uart_main_top #(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int W_OUT            = 16,
    parameter int BITS_PER_WORD    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    input  logic             s_valid,
    input  logic [W_OUT-1:0] s_data,
    output logic             tx_ready,
    output logic             tx,
    output logic             m_valid,
    output logic [W_OUT-1:0] m_data
);
    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int CNT_W     = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W     = $clog2(BITS_PER_WORD + 2);
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CNT_W-1:0] BIT_TC    = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [CNT_W-1:0] HALF_TC   = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [BIT_W-1:0] STOP_BIT  = BIT_W'(BITS_PER_WORD + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);

    // state    | meaning
    // TX_IDLE  | line high, ready for a word      TX_SEND  | shifting frames out
    // RX_IDLE  | waiting for falling edge         RX_START | confirming start at mid-bit
    // RX_DATA  | sampling data bits mid-bit       RX_STOP  | checking stop bit, storing byte
    typedef enum logic       {TX_IDLE, TX_SEND} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0] tx_bit_q, tx_bit_d;
    logic [IDX_W-1:0] tx_idx_q, tx_idx_d;
    logic [W_OUT-1:0] tx_shift_q, tx_shift_d;

    rx_state_e                rx_state_q, rx_state_d;
    logic                     rx_s1_q, rx_s2_q, rx_prev_q;
    logic [CNT_W-1:0]         rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]         rx_bit_q, rx_bit_d;
    logic [IDX_W-1:0]         rx_idx_q, rx_idx_d;
    logic [BITS_PER_WORD-1:0] rx_byte_q, rx_byte_d;
    logic [W_OUT-1:0]         rx_buf_q, rx_buf_d;
    logic [W_OUT-1:0]         m_data_q, m_data_d;
    logic                     m_valid_q, m_valid_d;
    logic [W_OUT-1:0]         rx_byte_ext;
    logic [W_OUT-1:0]         rx_buf_shifted;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            rx_state_q <= RX_IDLE;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_idx_q   <= '0;
            rx_byte_q  <= '0;
            rx_buf_q   <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            rx_state_q <= rx_state_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_idx_q   <= rx_idx_d;
            rx_byte_q  <= rx_byte_d;
            rx_buf_q   <= rx_buf_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
        end
    end

    // Data bits leave from bit 0; after a frame's data bits the next byte sits in the low bits.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx         = 1'b1;
        tx_ready   = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (s_valid) begin
                    tx_state_d = TX_SEND;
                    tx_cnt_d   = BIT_TC;
                    tx_bit_d   = '0;
                    tx_idx_d   = '0;
                    tx_shift_d = s_data;
                end
            end
            TX_SEND: begin
                if (tx_bit_q == '0)            tx = 1'b0;
                else if (tx_bit_q == STOP_BIT) tx = 1'b1;
                else                           tx = tx_shift_q[0];
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - CNT_W'(1);
                end else begin
                    tx_cnt_d = BIT_TC;
                    if (tx_bit_q == STOP_BIT) begin
                        tx_bit_d = '0;
                        if (tx_idx_q == LAST_IDX) tx_state_d = TX_IDLE;
                        else                      tx_idx_d   = tx_idx_q + IDX_W'(1);
                    end else begin
                        if (tx_bit_q != '0) tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Bytes enter the buffer from the top so frame 0 ends up in the low bits after NUM_WORDS frames.
    assign rx_byte_ext    = W_OUT'(rx_byte_q);
    assign rx_buf_shifted = (rx_buf_q >> BITS_PER_WORD) | (rx_byte_ext << (W_OUT - BITS_PER_WORD));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_idx_d   = rx_idx_q;
        rx_byte_d  = rx_byte_q;
        rx_buf_d   = rx_buf_q;
        m_data_d   = m_data_q;
        m_valid_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = HALF_TC;
                end
            end
            RX_START: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end else if (!rx_s2_q) begin
                    rx_state_d = RX_DATA;
                    rx_cnt_d   = BIT_TC;
                    rx_bit_d   = '0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end else begin
                    rx_cnt_d  = BIT_TC;
                    rx_byte_d = {rx_s2_q, rx_byte_q[BITS_PER_WORD-1:1]};
                    if (rx_bit_q == LAST_DATA) rx_state_d = RX_STOP;
                    else                       rx_bit_d   = rx_bit_q + BIT_W'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - CNT_W'(1);
                end else begin
                    rx_state_d = RX_IDLE;
                    if (rx_s2_q) begin
                        rx_buf_d = rx_buf_shifted;
                        if (rx_idx_q == LAST_IDX) begin
                            m_data_d  = rx_buf_shifted;
                            m_valid_d = 1'b1;
                            rx_idx_d  = '0;
                        end else begin
                            rx_idx_d = rx_idx_q + IDX_W'(1);
                        end
                    end else begin
                        rx_idx_d = '0;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_uart_main_top.sv
// Scoreboard bench for uart_main_top: expected words/bytes are queued at acceptance and
// popped by independent tx-line and m_valid monitors.
module tb_uart_main_top;
    localparam int CPP  = 16;
    localparam int W    = 16;
    localparam int BPW  = 8;
    localparam int NW   = W / BPW;
    localparam int BUSY = NW * 10 * CPP;

    logic          clk = 1'b0;
    logic          rst, rx, s_valid, tx_ready, tx, m_valid;
    logic [W-1:0]  s_data, m_data;
    logic          loop_en, rx_drv;

    assign rx = loop_en ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_main_top #(.CLOCKS_PER_PULSE(CPP), .W_OUT(W), .BITS_PER_WORD(BPW)) dut (
        .clk(clk), .rstn(rst), .rx(rx), .s_valid(s_valid), .s_data(s_data),
        .tx_ready(tx_ready), .tx(tx), .m_valid(m_valid), .m_data(m_data)
    );

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_words[$];
    logic [7:0]   exp_bytes[$];
    logic [W-1:0] last_word = '0;
    bit           rst_seen = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(string name, string info);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, info);
    endfunction

    always @(posedge rst) rst_seen = 1'b1;

    // Received-word monitor
    logic mv_prev = 1'b0;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_valid_one_cycle", mv_prev, 0);
            if (exp_words.size() == 0) begin
                fail("rx_unexpected_word", $sformatf("got %0h with nothing expected", m_data));
            end else begin
                logic [W-1:0] w;
                w = exp_words.pop_front();
                chk("rx_word", m_data, w);
                last_word = w;
            end
        end
        mv_prev = m_valid;
    end

    // Serial-line monitor: decodes 8N1 frames on tx at mid-bit
    initial begin
        logic       tx_prev;
        logic [7:0] b;
        logic       stop;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_prev && !tx && !rst) begin
                rst_seen = 1'b0;
                repeat (CPP / 2) @(negedge clk);
                chk("tx_start_mid", tx, 0);
                for (int i = 0; i < BPW; i++) begin
                    repeat (CPP) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPP) @(negedge clk);
                stop = tx;
                if (!rst_seen) begin
                    chk("tx_stop_bit", stop, 1);
                    if (exp_bytes.size() == 0) fail("tx_unexpected_frame", $sformatf("byte %0h", b));
                    else chk("tx_frame_byte", b, exp_bytes.pop_front());
                end
            end
            tx_prev = tx;
        end
    end

    task automatic send_word(input logic [W-1:0] d, input bit hold);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            fail("tx_ready_timeout", "transmitter never became ready");
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_words.push_back(d);
        for (int i = 0; i < NW; i++) exp_bytes.push_back(8'(d >> (8 * i)));
        @(negedge clk);
        if (!hold) s_valid = 1'b0;
        chk("start_bit_after_accept", tx, 0);
        chk("tx_ready_low_after_accept", tx_ready, 0);
    endtask

    task automatic wait_idle(output int busy);
        busy = 1;
        while (busy < 2000) begin
            @(negedge clk);
            if (tx_ready) break;
            busy++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_words.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (exp_words.size() != 0) fail("rx_drain_timeout", $sformatf("%0d words pending", exp_words.size()));
        repeat (CPP) @(negedge clk);
        chk("tx_bytes_left", exp_bytes.size(), 0);
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        repeat (CPP) @(negedge clk);
        for (int i = 0; i < BPW; i++) begin
            rx_drv = b[i];
            repeat (CPP) @(negedge clk);
        end
        rx_drv = stop;
        repeat (CPP) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        int           busy;
        logic [W-1:0] d;
        bit           hold;
        rst = 1'b1; loop_en = 1'b1; rx_drv = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_data", m_data, 16'h0000);

        // Loopback single word
        send_word(16'hA53C, 1'b0);
        wait_idle(busy);
        chk("busy_cycles", busy, BUSY);
        drain();

        // Back-to-back: second word held on s_valid while busy
        send_word(16'h1234, 1'b1);
        s_data = 16'hFFFF;
        send_word(16'hFFFF, 1'b0);
        wait_idle(busy);
        chk("busy_cycles_b2b", busy, BUSY);
        drain();

        // Busy ignore
        send_word(16'h0F1E, 1'b0);
        repeat (50) @(negedge clk);
        s_data = 16'hDEAD; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        chk("busy_ignore_ready", tx_ready, 0);
        wait_idle(busy);
        drain();
        repeat (400) @(negedge clk);

        // Glitch and framing error, driven directly on rx
        loop_en = 1'b0;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (300) @(negedge clk);
        rx_frame(8'h55, 1'b0);
        repeat (CPP) @(negedge clk);
        exp_words.push_back(16'h00FF);
        rx_frame(8'hFF, 1'b1);
        rx_frame(8'h00, 1'b1);
        drain();

        // Random words on rx with random inter-frame gaps
        for (int k = 0; k < 6; k++) begin
            d = 16'($urandom);
            exp_words.push_back(d);
            rx_frame(d[7:0], 1'b1);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            rx_frame(d[15:8], 1'b1);
            repeat ($urandom_range(0, 40)) @(negedge clk);
        end
        drain();

        // Random loopback words, randomly chained back-to-back
        loop_en = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            d    = 16'($urandom);
            hold = (k == 9) ? 1'b0 : 1'($urandom_range(0, 1));
            send_word(d, hold);
            if (!hold) begin
                wait_idle(busy);
                chk("busy_cycles_rand", busy, BUSY);
            end
        end
        drain();
        chk("m_data_hold", m_data, last_word);

        // Reset halfway through frame 1
        send_word(16'h1357, 1'b0);
        repeat (CPP * 10 + CPP * 5) @(negedge clk);
        rst = 1'b1;
        exp_words.delete();
        exp_bytes.delete();
        @(negedge clk);
        chk("midrst_tx", tx, 1);
        chk("midrst_tx_ready", tx_ready, 1);
        chk("midrst_m_valid", m_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (400) @(negedge clk);
        chk("midrst_m_data", m_data, 16'h0000);
        send_word(16'h5AA5, 1'b0);
        wait_idle(busy);
        chk("busy_cycles_after_rst", busy, BUSY);
        drain();
        chk("m_data_final", m_data, 16'h5AA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #800000;
        fail("watchdog", "simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_main_top.md
# uart_main_top

Parameterised full-duplex UART endpoint that moves multi-byte words over a serial link. The transmit side accepts a W_OUT-bit word on a valid/ready handshake and sends it as NUM_WORDS back-to-back 8N1 frames, least-significant byte first. The receive side reassembles NUM_WORDS frames from `rx` into one W_OUT-bit word and presents it with a one-cycle `m_valid` strobe. It sits between on-chip logic and the board UART pins.

## Interface
- CLOCKS_PER_PULSE, 16: clock cycles per serial bit; must be ≥ 4 and even.
- W_OUT, 16: width of the transmitted and received word; must be a multiple of BITS_PER_WORD.
- BITS_PER_WORD, 8: data bits per UART frame.
- NUM_WORDS (derived) = W_OUT / BITS_PER_WORD: frames per word.
- clk  in  1  single system clock; all logic is on its rising edge.
- rstn  in  1  reset; asynchronous, active-high (asserted when 1), despite the codebase port name.
- rx  in  1  serial input; idles high; asynchronous to clk.
- s_valid  in  1  transmit request.
- s_data  in  NUM_WORDS×BITS_PER_WORD (packed, = W_OUT)  transmit word; element [0] is sent first.
- tx_ready  out  1  transmitter idle; it can accept a word.
- tx  out  1  serial output; idles high.
- m_valid  out  1  one-cycle strobe: a full word has been received.
- m_data  out  W_OUT  last received word; frame 0 is placed in bits [BITS_PER_WORD-1:0].

## Operation
- Frame format (8N1): one start bit (0), BITS_PER_WORD data bits sent LSB first, one stop bit (1). Each bit lasts exactly CLOCKS_PER_PULSE cycles.
- TX states:
  - IDLE: tx=1, tx_ready=1. When s_valid=1 and tx_ready=1 on a rising edge, capture s_data, clear the word index, and go to SEND.
  - SEND: shift out a frame from the bit counter (0 = start, 1..BITS_PER_WORD = data, BITS_PER_WORD+1 = stop).
  - After the stop bit: if the word index < NUM_WORDS-1, increment it and start the next frame immediately, with no idle gap. Otherwise return to IDLE.
  - s_valid is ignored while tx_ready=0. Captured data is not affected by later changes to s_data.
- RX path: rx passes through a 2-flop synchroniser before use.
- RX states:
  - IDLE: a synchronised 1→0 transition moves to START.
  - START: wait CLOCKS_PER_PULSE/2 cycles. If rx is still 0 go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: sample every CLOCKS_PER_PULSE cycles (mid-bit), BITS_PER_WORD samples, LSB first.
  - STOP: sample one bit period later. If the sample is 1, store the byte at the current word index. If the sample is 0, it is a framing error: drop the byte and reset the word index to 0.
- RX word assembly: after the stop sample of word NUM_WORDS-1, update m_data with all stored bytes, pulse m_valid, and reset the word index to 0. m_data holds its value until the next completed word.
- TX and RX operate fully independently. Loopback is external: connect rx to tx.
- Reset: tx=1, tx_ready=1, m_valid=0, m_data=0, both state machines go to IDLE, and all counters are 0. Reset during a transfer aborts it immediately and the partial word is discarded.

## Timing
- Acceptance edge E: tx_ready=0 from E+1. The start bit appears on tx from E+1.
- Each frame occupies 10×CLOCKS_PER_PULSE cycles on tx; the whole word occupies NUM_WORDS×10×CLOCKS_PER_PULSE cycles (320 at defaults).
- tx_ready returns to 1 on the cycle after the last stop bit completes. It is a level signal, not a pulse.
- s_valid held high across that edge starts the next word with no gap.
- RX latency: m_valid rises 2 cycles (synchroniser) plus 9.5 bit periods after the last frame's start edge reaches rx, ±1 cycle. It lasts exactly 1 cycle.
- A new start bit is detected no earlier than the cycle after the stop sample. Inter-frame gaps of any length are accepted.

## Test plan
- Reset: hold rstn=1 for 2 cycles, then release → tx=1, tx_ready=1, m_valid=0, m_data=16'h0000.
- Loopback single word: rx=tx, send s_data=16'hA53C → tx shows frame 0x3C then frame 0xA5, 160 cycles each. One m_valid pulse with m_data=16'hA53C; tx_ready=1 about 320 cycles after acceptance.
- Back-to-back: send 16'h1234, then assert s_valid on the rising edge of tx_ready with 16'hFFFF → m_valid fires twice, with 16'h1234 then 16'hFFFF. Tx has no idle gap.
- Busy ignore: pulse s_valid with 16'hDEAD while tx_ready=0 → no effect; only the original word is received.
- Glitch/framing: drive an rx low pulse of 4 cycles → no reception. Drive a frame whose stop bit is 0 → no m_valid, and the following good 2-frame word 16'h00FF is received correctly.
- Reset mid-transfer: assert rstn halfway through frame 1 → tx=1 and tx_ready=1 immediately, no m_valid. The next full transfer of 16'h5AA5 succeeds.
